sd_resp_rx: RTL

SD_RESP_RX -- requirements
Module: sd_resp_rx

---
 rtl/sd_host_pkg.sv | 25 ++
 rtl/sd_crc7.sv | 26 ++
 rtl/sd_resp_rx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sd_host_pkg.sv
// Shared definitions for the SD host command-path blocks: receiver FSM
// states, frame lengths, CRC7 polynomial and the R2 index code.
package sd_host_pkg;

  typedef logic [1:0] sd_state_t;

  localparam sd_state_t ST_IDLE       = 2'd0;
  localparam sd_state_t ST_WAIT_START = 2'd1;
  localparam sd_state_t ST_RECEIVE    = 2'd2;
  localparam sd_state_t ST_CHECK      = 2'd3;

  localparam int SHORT_LEN = 48;
  localparam int LONG_LEN  = 136;

  localparam logic [6:0] CRC7_POLY    = 7'h09;
  localparam logic [5:0] R2_CMD_INDEX = 6'h3F;

  // One serial CRC7 step, MSB-first, for x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 generator (x^7 + x^3 + 1, seed 0), one bit per enabled cycle.
// The serial input is named bit_in because "bit" is a reserved word.
module sd_crc7
  import sd_host_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] crc_p0;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc_p0 <= 7'h00;
    end else if (enable) begin
      crc_p0 <= crc7_step(crc_p0, bit_in);
    end
  end

  assign crc = crc_p0;

endmodule

// File: rtl/sd_resp_rx.sv
// SD CMD-line response receiver: 48-bit and 136-bit (R2) frames with timeout,
// end-bit check and optional CRC7 check (macro SD_RESP_CRC_CHK_EN).
module sd_resp_rx
  import sd_host_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sd_tick,
  input  logic         cmd_in,
  input  logic         arm,
  input  logic         long_resp,
  output logic         busy,
  output logic         resp_valid,
  output logic [127:0] response,
  output logic [5:0]   cmd_index,
  output logic         crc_err,
  output logic         end_err,
  output logic         timeout_err
);

  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam int CNT_W = $clog2(LONG_LEN + 1);
  // Frame bits above 127 (start/tx/reserved of R2) are never decoded, so the
  // register keeps 127 bits and the incoming bit completes a 128-bit view.
  localparam int SHIFT_W = 127;

  function automatic logic [127:0] decode_payload(input logic [119:0] body, input logic lng);
    if (lng) return {8'h00, body};
    return {96'h0, body[31:0]};
  endfunction

  sd_state_t            state_p0;
  logic                 long_p0;
  logic [CNT_W-1:0]     bit_cnt_p0;
  logic [TO_W-1:0]      to_cnt_p0;
  logic [SHIFT_W-1:0]   shreg_p0;
  logic [127:0]         response_p0;
  logic [5:0]           cmd_index_p0;
  logic                 end_err_p0;
  logic                 timeout_err_p0;

  logic [127:0]         shreg_nxt;
  logic [CNT_W-1:0]     bit_cnt_nxt;
  logic [TO_W-1:0]      to_cnt_nxt;
  logic [CNT_W-1:0]     frame_len;
  logic                 accept_arm;
  logic                 start_bit;
  logic                 timeout_hit;
  logic                 rx_done;
  logic                 shift_en;

  always_comb begin
    shreg_nxt   = {shreg_p0, cmd_in};
    bit_cnt_nxt = bit_cnt_p0 + CNT_W'(1);
    to_cnt_nxt  = to_cnt_p0 + TO_W'(1);
    frame_len   = long_p0 ? CNT_W'(LONG_LEN) : CNT_W'(SHORT_LEN);
    accept_arm  = (state_p0 == ST_IDLE) && arm;
    start_bit   = (state_p0 == ST_WAIT_START) && sd_tick && !cmd_in;
    timeout_hit = (state_p0 == ST_WAIT_START) && sd_tick && cmd_in &&
                  (to_cnt_nxt == TO_W'(TIMEOUT_TICKS));
    rx_done     = (state_p0 == ST_RECEIVE) && sd_tick && (bit_cnt_nxt == frame_len);
    shift_en    = start_bit || ((state_p0 == ST_RECEIVE) && sd_tick);
  end

  // ---- control stage: FSM, counters, status flags ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0       <= ST_IDLE;
      long_p0        <= 1'b0;
      bit_cnt_p0     <= '0;
      to_cnt_p0      <= '0;
      end_err_p0     <= 1'b0;
      timeout_err_p0 <= 1'b0;
    end else begin
      case (state_p0)
        ST_IDLE: begin
          if (arm) begin
            state_p0       <= ST_WAIT_START;
            long_p0        <= long_resp;
            bit_cnt_p0     <= '0;
            to_cnt_p0      <= '0;
            end_err_p0     <= 1'b0;
            timeout_err_p0 <= 1'b0;
          end
        end
        ST_WAIT_START: begin
          if (start_bit) begin
            state_p0   <= ST_RECEIVE;
            bit_cnt_p0 <= CNT_W'(1);
          end else if (timeout_hit) begin
            state_p0       <= ST_CHECK;
            timeout_err_p0 <= 1'b1;
          end else if (sd_tick) begin
            to_cnt_p0 <= to_cnt_nxt;
          end
        end
        ST_RECEIVE: begin
          if (sd_tick) begin
            bit_cnt_p0 <= bit_cnt_nxt;
            if (rx_done) begin
              state_p0   <= ST_CHECK;
              end_err_p0 <= ~cmd_in;
            end
          end
        end
        ST_CHECK: begin
          state_p0 <= ST_IDLE;
        end
        default: begin
          state_p0 <= ST_IDLE;
        end
      endcase
    end
  end

  // ---- data stage: shift register and decoded result registers ----
  // Results load on the edge that enters CHECK so they are valid together
  // with resp_valid; a timeout never reaches this load and leaves them intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_p0     <= '0;
      response_p0  <= '0;
      cmd_index_p0 <= '0;
    end else begin
      if (accept_arm) begin
        shreg_p0 <= '0;
      end else if (shift_en) begin
        shreg_p0 <= shreg_nxt[SHIFT_W-1:0];
      end
      if (rx_done) begin
        response_p0  <= decode_payload(shreg_nxt[127:8], long_p0);
        cmd_index_p0 <= long_p0 ? R2_CMD_INDEX : shreg_nxt[45:40];
      end
    end
  end

`ifdef SD_RESP_CRC_CHK_EN
  localparam int SHORT_CRC_LAST = SHORT_LEN - 8;
  localparam int LONG_CRC_FIRST = LONG_LEN - 127;
  localparam int LONG_CRC_LAST  = LONG_LEN - 8;

  logic [6:0] crc_val;
  logic       crc_en;
  logic       crc_err_p0;

  // Coverage by 1-based bit position: short frames include the start bit,
  // R2 frames skip their first 8 bits.
  always_comb begin
    crc_en = 1'b0;
    if (start_bit) begin
      crc_en = !long_p0;
    end else if ((state_p0 == ST_RECEIVE) && sd_tick) begin
      if (long_p0) begin
        crc_en = (bit_cnt_nxt >= CNT_W'(LONG_CRC_FIRST)) &&
                 (bit_cnt_nxt <= CNT_W'(LONG_CRC_LAST));
      end else begin
        crc_en = (bit_cnt_nxt <= CNT_W'(SHORT_CRC_LAST));
      end
    end
  end

  sd_crc7 u_crc7 (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept_arm),
    .enable (crc_en),
    .bit_in (cmd_in),
    .crc    (crc_val)
  );

  always_ff @(posedge clk) begin
    if (rst || accept_arm) begin
      crc_err_p0 <= 1'b0;
    end else if (rx_done) begin
      crc_err_p0 <= (crc_val != shreg_nxt[7:1]);
    end
  end

  assign crc_err = crc_err_p0;
`else
  assign crc_err = 1'b0;
`endif

  assign busy        = (state_p0 == ST_WAIT_START) || (state_p0 == ST_RECEIVE);
  assign resp_valid  = (state_p0 == ST_CHECK);
  assign response    = response_p0;
  assign cmd_index   = cmd_index_p0;
  assign end_err     = end_err_p0;
  assign timeout_err = timeout_err_p0;

endmodule
